// File: rtl/channel_readout_ctrl_if.sv
// Event stream from a channel controller to the chip-level readout arbiter.
// The head word is offered with valid and taken when ready is also high.
interface channel_readout_ctrl_if #(
    parameter int unsigned WIDTH = 35
);
    logic [WIDTH-1:0] event_data;
    logic             event_valid;
    logic             event_ready;

    modport master (output event_data, output event_valid, input event_ready);
    modport slave  (input event_data, input event_valid, output event_ready);
endinterface

// File: rtl/channel_readout_ctrl.sv
// Per-channel readout controller: trigger -> sample -> ADC convert -> push
// {timeout, timestamp, adc} into an FWFT FIFO, then hold the CSA in reset.
module channel_readout_ctrl #(
    parameter int unsigned ADCBITS      = 10,
    parameter int unsigned TS_BITS      = 24,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CONV_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       hit_i,
    input  logic                       ext_trig_i,
    input  logic                       channel_mask_i,
    input  logic [3:0]                 sample_cycles_i,
    input  logic [7:0]                 reset_length_i,
    input  logic [ADCBITS-1:0]         adc_dout_i,
    input  logic                       adc_done_i,
    output logic                       sample_o,
    output logic                       strobe_o,
    output logic                       csa_reset_o,
    channel_readout_ctrl_if.master     event_if,
    output logic                       fifo_overflow_o,
    output logic [7:0]                 overflow_count_o
);
    localparam int unsigned EW = 1 + TS_BITS + ADCBITS;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = ($clog2(CONV_TIMEOUT) > 8) ? $clog2(CONV_TIMEOUT) : 8;

    typedef enum logic [2:0] {CSA_RST, IDLE, SAMPLE, CONVERT, WRITE} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TS_BITS-1:0]  ts_q;
    logic [2:0]          hit_sync_q;
    logic                rise_q;
    logic [TS_BITS-1:0]  ev_ts_q, ev_ts_d;
    logic [ADCBITS-1:0]  ev_adc_q, ev_adc_d;
    logic                ev_to_q, ev_to_d;
    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          ovc_q, ovc_d;

    logic [CW-1:0]       sc_len, rl_len;
    logic                trigger, push, push_ok, pop, full, empty;

    always_comb begin
        sc_len = CW'(sample_cycles_i);
        if (sample_cycles_i == '0) sc_len = CW'(1);
        rl_len = CW'(reset_length_i);
        if (reset_length_i == '0) rl_len = CW'(1);
    end

    // Registered edge detect on the synchronised hit puts the trigger 3 cycles after hit.
    assign trigger = (rise_q & ~channel_mask_i) | ext_trig_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ev_ts_d     = ev_ts_q;
        ev_adc_d    = ev_adc_q;
        ev_to_d     = ev_to_q;
        push        = 1'b0;
        sample_o    = 1'b0;
        strobe_o    = 1'b0;
        csa_reset_o = 1'b0;
        case (state_q)
            CSA_RST: begin
                csa_reset_o = 1'b1;
                if (cnt_q <= CW'(1)) state_d = IDLE;
                else                 cnt_d   = cnt_q - CW'(1);
            end
            IDLE: begin
                if (trigger) begin
                    ev_ts_d = ts_q;
                    cnt_d   = sc_len;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                sample_o = 1'b1;
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = CONVERT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            CONVERT: begin
                strobe_o = 1'b1;
                if (adc_done_i) begin
                    ev_adc_d = adc_dout_i;
                    ev_to_d  = 1'b0;
                    state_d  = WRITE;
                end else if (cnt_q == CW'(CONV_TIMEOUT - 1)) begin
                    ev_adc_d = adc_dout_i;
                    ev_to_d  = 1'b1;
                    state_d  = WRITE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WRITE: begin
                push    = 1'b1;
                cnt_d   = rl_len;
                state_d = CSA_RST;
            end
            default: begin
                cnt_d   = rl_len;
                state_d = CSA_RST;
            end
        endcase
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = ~empty & event_if.event_ready;
    assign push_ok = push & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        ovc_d    = ovc_q;
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else if (push) begin
            ovf_d = 1'b1;
            if (ovc_q != '1) ovc_d = ovc_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CSA_RST;
            cnt_q      <= rl_len;
            ts_q       <= '0;
            hit_sync_q <= '0;
            rise_q     <= 1'b0;
            ev_ts_q    <= '0;
            ev_adc_q   <= '0;
            ev_to_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            ovc_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ts_q       <= ts_q + TS_BITS'(1);
            hit_sync_q <= {hit_sync_q[1:0], hit_i};
            rise_q     <= hit_sync_q[1] & ~hit_sync_q[2];
            ev_ts_q    <= ev_ts_d;
            ev_adc_q   <= ev_adc_d;
            ev_to_q    <= ev_to_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            ovc_q      <= ovc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {ev_to_q, ev_ts_q, ev_adc_q};
    end

    assign event_if.event_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign event_if.event_valid = ~empty;
    assign fifo_overflow_o      = ovf_q;
    assign overflow_count_o     = ovc_q;
endmodule

// File: tb/tb_channel_readout_ctrl.sv
// Bench for channel_readout_ctrl: stimulus predicts each event's timeline and
// word from cycle arithmetic; a negedge monitor checks controls and the FIFO.
module tb_channel_readout_ctrl;
    localparam int unsigned ADC  = 10;
    localparam int unsigned TS   = 10;
    localparam int unsigned DEP  = 4;
    localparam int unsigned CT   = 64;
    localparam int unsigned EW   = 1 + TS + ADC;

    typedef struct {
        int            cyc;
        logic [EW-1:0] word;
    } pend_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           hit = 1'b0, ext_trig = 1'b0, channel_mask = 1'b0;
    logic [3:0]     sample_cycles = 4'd1;
    logic [7:0]     reset_length = 8'd5;
    logic [ADC-1:0] adc_dout = '0;
    logic           adc_done = 1'b0;
    logic           ready = 1'b0;
    logic           sample, strobe, csa_reset, fifo_overflow;
    logic [7:0]     overflow_count;

    channel_readout_ctrl_if #(.WIDTH(EW)) ev_if ();
    assign ev_if.event_ready = ready;

    channel_readout_ctrl #(
        .ADCBITS(ADC), .TS_BITS(TS), .FIFO_DEPTH(DEP), .CONV_TIMEOUT(CT)
    ) dut (
        .clk(clk), .reset(reset), .hit_i(hit), .ext_trig_i(ext_trig),
        .channel_mask_i(channel_mask), .sample_cycles_i(sample_cycles),
        .reset_length_i(reset_length), .adc_dout_i(adc_dout), .adc_done_i(adc_done),
        .sample_o(sample), .strobe_o(strobe), .csa_reset_o(csa_reset),
        .event_if(ev_if), .fifo_overflow_o(fifo_overflow),
        .overflow_count_o(overflow_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference state
    int            checks = 0, errors = 0;
    int            rst_cyc = 0, idle_from = 0;
    bit            chk_en = 1'b0;
    logic [2:0]    exp_ctrl [int];
    logic [EW-1:0] exp_q [$];
    pend_t         pend_q [$];
    bit            m_ovf = 1'b0;
    int            m_ovc = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [TS-1:0] ts_at(input int n);
        int d;
        d = n - rst_cyc;
        return d[TS-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: FIFO occupancy, head word and flags follow the queue model
    always @(negedge clk) begin
        bit popped, was_full;
        if (chk_en) begin
            if (exp_ctrl.exists(cyc)) begin
                check("ctrl{csa,strobe,sample}", {61'd0, csa_reset, strobe, sample}, {61'd0, exp_ctrl[cyc]});
                exp_ctrl.delete(cyc);
            end
            check("event_valid", {63'd0, ev_if.event_valid}, {63'd0, exp_q.size() != 0});
            if (exp_q.size() != 0)
                check("event_data", 64'(ev_if.event_data), 64'(exp_q[0]));
            check("fifo_overflow", {63'd0, fifo_overflow}, {63'd0, m_ovf});
            check("overflow_count", {56'd0, overflow_count}, 64'(m_ovc));
            was_full = (exp_q.size() == DEP);
            popped   = (exp_q.size() != 0) && ready;
            if (popped) void'(exp_q.pop_front());
            if (pend_q.size() != 0 && pend_q[0].cyc == cyc) begin
                if (!was_full || popped) exp_q.push_back(pend_q[0].word);
                else begin
                    m_ovf = 1'b1;
                    if (m_ovc < 255) m_ovc++;
                end
                void'(pend_q.pop_front());
            end
        end
    end

    task automatic do_reset(input int rl);
        int rlp;
        chk_en = 1'b0;
        reset = 1'b1;
        reset_length = 8'(rl);
        hit = 1'b0; ext_trig = 1'b0; adc_done = 1'b0;
        repeat (3) tick();
        exp_q.delete(); pend_q.delete(); exp_ctrl.delete();
        m_ovf = 1'b0; m_ovc = 0;
        reset = 1'b0;
        rst_cyc = cyc;
        rlp = (rl == 0) ? 1 : rl;
        for (int n = 0; n < rlp; n++) exp_ctrl[cyc + n] = 3'b100;
        exp_ctrl[cyc + rlp] = 3'b000;
        idle_from = cyc + rlp;
        chk_en = 1'b1;
    endtask

    // rmode: 0 keep ready, 1 ready only in the WRITE cycle, 2 random ready per cycle
    task automatic run_event(input bit use_hit, input int sc, input int delay,
                             input logic [ADC-1:0] adc, input int rl, input int rmode);
        int scp, rlp, t, c0, conv, w;
        bit tof;
        pend_t p;
        scp = (sc == 0) ? 1 : sc;
        rlp = (rl == 0) ? 1 : rl;
        sample_cycles = 4'(sc);
        reset_length  = 8'(rl);
        adc_dout      = adc;
        if (use_hit) begin
            while (cyc + 3 < idle_from) tick();
            hit = 1'b1;
            t = cyc + 3;
        end else begin
            while (cyc < idle_from) tick();
            ext_trig = 1'b1;
            t = cyc;
        end
        tof  = (delay >= CT);
        conv = tof ? CT : delay + 1;
        c0   = t + scp + 1;
        w    = c0 + conv;
        exp_ctrl[t] = 3'b000;
        for (int n = t + 1; n < c0; n++) exp_ctrl[n] = 3'b001;
        for (int n = c0; n < w; n++) exp_ctrl[n] = 3'b010;
        exp_ctrl[w] = 3'b000;
        for (int n = w + 1; n <= w + rlp; n++) exp_ctrl[n] = 3'b100;
        exp_ctrl[w + rlp + 1] = 3'b000;
        p.cyc  = w;
        p.word = {tof, ts_at(t), adc};
        pend_q.push_back(p);
        tick();
        ext_trig = 1'b0;
        if (use_hit) begin
            tick();
            hit = 1'b0;
        end
        while (cyc <= w) begin
            adc_done = !tof && (cyc >= c0 + delay);
            if (rmode == 1) ready = (cyc == w);
            else if (rmode == 2) ready = 1'($urandom_range(0, 1));
            tick();
        end
        adc_done = 1'b0;
        if (rmode == 1) ready = 1'b0;
        adc_dout = ADC'($urandom);
        idle_from = w + rlp + 1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and csa_reset length
        do_reset(5);
        repeat (8) tick();

        // Hit-triggered event, done 10 cycles into CONVERT
        ready = 1'b1;
        channel_mask = 1'b0;
        run_event(1'b1, 3, 10, 10'h2A5, 5, 0);

        // Conversion timeout
        run_event(1'b0, 2, 200, 10'h13C, 4, 0);

        // Masked hits produce nothing; ext_trig still honoured while masked
        while (cyc < idle_from) tick();
        channel_mask = 1'b1;
        for (int n = 0; n < 16; n++) exp_ctrl[cyc + n] = 3'b000;
        repeat (2) begin
            hit = 1'b1; repeat (3) tick();
            hit = 1'b0; repeat (3) tick();
        end
        repeat (4) tick();
        run_event(1'b0, 1, 5, 10'h3FF, 2, 0);
        channel_mask = 1'b0;
        repeat (4) tick();

        // Six events into a 4-deep FIFO with no consumer, then drain
        do_reset(3);
        ready = 1'b0;
        for (int i = 0; i < 6; i++) run_event(1'b0, 1, 2, ADC'(i * 77 + 5), 2, 0);
        repeat (4) tick();
        ready = 1'b1;
        repeat (10) tick();

        // Full FIFO with a pop in the WRITE cycle: push accepted
        do_reset(2);
        ready = 1'b0;
        for (int i = 0; i < 4; i++) run_event(1'b0, 0, 1, ADC'(i + 100), 0, 0);
        run_event(1'b0, 2, 3, 10'h155, 2, 1);
        repeat (4) tick();
        ready = 1'b1;
        repeat (8) tick();

        // Timestamp wrap: first event at the last count, second after wrap
        while (!(cyc >= idle_from && ts_at(cyc) == '1)) tick();
        run_event(1'b0, 1, 0, 10'h001, 1, 0);
        run_event(1'b0, 1, 0, 10'h002, 1, 0);
        repeat (4) tick();

        // Reset in the middle of an event aborts it
        while (cyc < idle_from) tick();
        sample_cycles = 4'd2;
        ext_trig = 1'b1; tick(); ext_trig = 1'b0;
        repeat (6) tick();
        do_reset(4);
        repeat (6) tick();

        // Randomised events with random consumer back-pressure
        for (int i = 0; i < 14; i++) begin
            run_event(1'($urandom_range(0, 1)), $urandom_range(0, 15),
                      ($urandom_range(0, 5) == 0) ? 70 : $urandom_range(0, 20),
                      ADC'($urandom), $urandom_range(0, 12), 2);
        end
        ready = 1'b1;
        while (cyc < idle_from) tick();
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
